// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED arbiter: FSM state encoding, LED width
// and the dwell-counter width calculation.
package led_arb_pkg;

   localparam int LED_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

   // Wide enough to hold DWELL_CYCLES itself, so the counter never needs to wrap.
   function automatic int dwell_width(input int dwell_cycles);
      return $clog2(dwell_cycles + 1);
   endfunction

endpackage

// File: rtl/led_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req from base+1 upward, wrapping,
// with base itself tried last (or skipped entirely when exclude_base is set).
module rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   base,
   input  logic               exclude_base,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   always_comb begin
      logic [IDX_W-1:0] idx;
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(base) + k) % NUM_REQ);
         if (!valid && req[idx] && !(exclude_base && (k == NUM_REQ))) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the board LEDs with a minimum per-owner dwell time.
// Build option LED_ACTIVE_LOW_EN: leds drives the inverse of the logical value.
module led_arbiter
   import led_arb_pkg::*;
#(
   parameter int               NUM_REQ      = 4,
   parameter int               DWELL_CYCLES = 13300000,
   parameter logic [LED_W-1:0] IDLE_PATTERN = 8'h00
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [LED_W*NUM_REQ-1:0] pattern,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic [LED_W-1:0]         leds
);

   localparam int               IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int               DW           = dwell_width(DWELL_CYCLES);
   localparam logic [DW-1:0]    DWELL_RELOAD = DW'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);

   arb_state_t         state_q, state_d;
   logic [DW-1:0]      dwell_q, dwell_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [LED_W-1:0]   leds_q, leds_d;
   logic [LED_W-1:0]   owner_pattern;
   logic [IDX_W-1:0]   pick_winner;
   logic               pick_valid;
   logic               pick_exclude;

   // The register holds the physical drive level, so the polarity choice is made once here.
   function automatic logic [LED_W-1:0] led_drive(input logic [LED_W-1:0] v);
`ifdef LED_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign owner_pattern = pattern[owner_q*LED_W +: LED_W];
   // In OWN the current owner only keeps the LEDs if nobody else is waiting.
   assign pick_exclude  = (state_q == OWN);

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req          (req),
      .base         (owner_q),
      .exclude_base (pick_exclude),
      .winner       (pick_winner),
      .valid        (pick_valid)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
         dwell_q <= '0;
         owner_q <= LAST_IDX;
         grant_q <= '0;
         leds_q  <= led_drive(IDLE_PATTERN);
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         leds_q  <= leds_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      owner_d = owner_q;
      grant_d = grant_q;
      leds_d  = leds_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = OWN;
               grant_d = onehot(pick_winner);
               owner_d = pick_winner;
               dwell_d = DWELL_RELOAD;
            end
         end
         OWN: begin
            if (dwell_q != '0) begin
               dwell_d = dwell_q - 1'b1;
               if (!req[owner_q]) begin
                  state_d = HOLD;
                  grant_d = '0;
               end else begin
                  leds_d = led_drive(owner_pattern);
               end
            end else begin
               leds_d = led_drive(owner_pattern);
               if (pick_valid) begin
                  grant_d = onehot(pick_winner);
                  owner_d = pick_winner;
                  dwell_d = DWELL_RELOAD;
               end else if (req[owner_q]) begin
                  dwell_d = DWELL_RELOAD;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  leds_d  = led_drive(IDLE_PATTERN);
               end
            end
         end
         HOLD: begin
            // LEDs stay frozen on the released owner's pattern until the dwell runs out.
            if (dwell_q != '0) begin
               dwell_d = dwell_q - 1'b1;
            end else if (pick_valid) begin
               state_d = OWN;
               grant_d = onehot(pick_winner);
               owner_d = pick_winner;
               dwell_d = DWELL_RELOAD;
            end else begin
               state_d = IDLE;
               leds_d  = led_drive(IDLE_PATTERN);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);
   assign leds  = leds_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with NUM_REQ=4, DWELL_CYCLES=4, IDLE_PATTERN=8'h00.
module tb_led_arbiter;
   import led_arb_pkg::*;

   localparam int         NUM_REQ  = 4;
   localparam int         DWELL    = 4;
   localparam logic [7:0] IDLE_PAT = 8'h00;

   logic                 clock = 1'b0;
   logic                 resetn;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] pattern;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic [7:0]           leds;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_grant;

   // clock / reset
   always #5 clock = ~clock;

   led_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .DWELL_CYCLES (DWELL),
      .IDLE_PATTERN (IDLE_PAT)
   ) dut (
      .clock   (clock),
      .resetn  (resetn),
      .req     (req),
      .pattern (pattern),
      .grant   (grant),
      .busy    (busy),
      .leds    (leds)
   );

   function automatic logic [7:0] exp_leds(input logic [7:0] v);
`ifdef LED_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      req    = '0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn  = 1'b0;
      req     = '0;
      pattern = {8'hC3, 8'h5A, 8'h3C, 8'hA5};

      // reset values
      apply_reset();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_leds", 32'(leds), 32'(exp_leds(8'h00)));

      // req 0110: requester 1 first, then 2 at dwell expiry
      req = 4'b0110;
      tick();
      check("t1_grant_c1", 32'(grant), 32'h2);
      check("t1_busy_c1", 32'(busy), 32'h1);
      tick();
      check("t1_leds_c2", 32'(leds), 32'(exp_leds(8'h3C)));
      check("t1_grant_c2", 32'(grant), 32'h2);
      tick();
      check("t1_grant_c3", 32'(grant), 32'h2);
      tick();
      check("t1_grant_c4", 32'(grant), 32'h2);
      tick();
      check("t1_grant_c5", 32'(grant), 32'h4);

      // all requesting: 0,1,2,3,0 with 4 cycles each
      apply_reset();
      for (int c = 1; c <= 20; c++) begin
         exp_grant = 4'b0001 << (((c - 1) / DWELL) % NUM_REQ);
         exp_q.push_back(exp_grant);
      end
      req = 4'b1111;
      while (exp_q.size() > 0) begin
         tick();
         exp_grant = exp_q.pop_front();
         check("rr_grant", 32'(grant), 32'(exp_grant));
         check("rr_onehot", 32'($countones(grant) <= 1), 32'h1);
      end

      // owner 0 releases early: grant drops, leds hold, then idle
      apply_reset();
      req = 4'b0001;
      tick();
      check("t3_grant_c1", 32'(grant), 32'h1);
      tick();
      check("t3_leds_c2", 32'(leds), 32'(exp_leds(8'hA5)));
      req = 4'b0000;
      tick();
      check("t3_grant_c3", 32'(grant), 32'h0);
      check("t3_leds_c3", 32'(leds), 32'(exp_leds(8'hA5)));
      check("t3_busy_c3", 32'(busy), 32'h1);
      tick();
      check("t3_leds_c4", 32'(leds), 32'(exp_leds(8'hA5)));
      check("t3_busy_c4", 32'(busy), 32'h1);
      tick();
      check("t3_leds_c5", 32'(leds), 32'(exp_leds(8'h00)));
      check("t3_busy_c5", 32'(busy), 32'h0);

      // owner 2, requester 3 joins mid-dwell: direct handover at expiry
      apply_reset();
      req = 4'b0100;
      tick();
      check("t4_grant_c1", 32'(grant), 32'h4);
      tick();
      req = 4'b1100;
      check("t4_leds_c2", 32'(leds), 32'(exp_leds(8'h5A)));
      check("t4_grant_c2", 32'(grant), 32'h4);
      tick();
      check("t4_grant_c3", 32'(grant), 32'h4);
      tick();
      check("t4_grant_c4", 32'(grant), 32'h4);
      tick();
      check("t4_grant_c5", 32'(grant), 32'h8);
      tick();
      check("t4_leds_c6", 32'(leds), 32'(exp_leds(8'hC3)));

      // reset mid-OWN of requester 1, then requester 0 wins over 1
      apply_reset();
      req = 4'b0010;
      tick();
      check("t5_grant_c1", 32'(grant), 32'h2);
      tick();
      check("t5_leds_c2", 32'(leds), 32'(exp_leds(8'h3C)));
      resetn = 1'b0;
      req    = 4'b0011;
      tick();
      check("t5_rst_grant", 32'(grant), 32'h0);
      check("t5_rst_busy", 32'(busy), 32'h0);
      check("t5_rst_leds", 32'(leds), 32'(exp_leds(8'h00)));
      resetn = 1'b1;
      tick();
      check("t5_first_win", 32'(grant), 32'h1);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
